ack_or: RTL and testbench

Four-input acknowledge combiner placed between four bus slaves and the single master-side `ack` line. It merges the slave acknowledges into one combinational `ack` with zero latency. It also reports which slave acknowledged and flags protocol violations where more than one slave acknowledges at the same time. The violation flags are sticky and clocked, so system firmware or the bench can read them after the fact.

---
 rtl/ack_pkg.sv | 19 +
 rtl/ack_or_if.sv | 17 +
 rtl/ack_sat_cnt.sv | 20 ++
 rtl/ack_or.sv | 62 ++++++
 tb/tb_ack_or.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/ack_pkg.sv
// Shared types and constants for the four-source acknowledge combiner.
package ack_pkg;

  localparam int NUM_SRC = 4;

  typedef logic [1:0]         src_idx_t;
  typedef logic [NUM_SRC-1:0] src_mask_t;

  localparam logic ASSERTED = 1'b1;
  localparam logic NEGATED  = 1'b0;

  function automatic logic [2:0] popcount(input src_mask_t mask);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_SRC; i++) n = n + {2'b00, mask[i]};
    return n;
  endfunction

endpackage

// File: rtl/ack_or_if.sv
// Acknowledge bundle between the slaves, the combiner and the master.
interface ack_or_if;
  import ack_pkg::*;

  logic     ack0;
  logic     ack1;
  logic     ack2;
  logic     ack3;
  logic     ack;
  src_idx_t ack_src;
  logic     ack_multi;

  // Slaves drive the individual acknowledges; the master sees the merged view.
  modport slave  (output ack0, ack1, ack2, ack3);
  modport master (input ack, ack_src, ack_multi);

endinterface

// File: rtl/ack_sat_cnt.sv
// Saturating up-counter: async active-low reset, sync clear, count enable.
module ack_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/ack_or.sv
// Merges four slave acknowledges into one combinational ack, with source
// encode, multi-ack detect, sticky violation flags and per-source counters.
module ack_or
  import ack_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             ack0,
  input  logic             ack1,
  input  logic             ack2,
  input  logic             ack3,
  output logic             ack,
  input  logic             clk,
  input  logic             rst,
  output src_idx_t         ack_src,
  output logic             ack_multi,
  output logic             err_multi,
  output src_mask_t        err_src,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  input  logic             clr
);

  src_mask_t acks;

  assign acks      = {ack3, ack2, ack1, ack0};
  assign ack       = |acks;
  assign ack_multi = (popcount(acks) >= 3'd2);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ack_src = src_idx_t'(0);
    if      (ack0 == ASSERTED) ack_src = src_idx_t'(0);
    else if (ack1 == ASSERTED) ack_src = src_idx_t'(1);
    else if (ack2 == ASSERTED) ack_src = src_idx_t'(2);
    else if (ack3 == ASSERTED) ack_src = src_idx_t'(3);
  end

  // NOTE: only the small flag/counter registers are reset; rst is the
  // active-low async reset, and clr wins over a coincident multi-ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_multi <= NEGATED;
      err_src   <= '0;
    end else if (clr) begin
      err_multi <= NEGATED;
      err_src   <= '0;
    end else if (ack_multi) begin
      err_multi <= ASSERTED;
      err_src   <= err_src | acks;
    end
  end

  ack_sat_cnt #(.W(CNT_W)) u_cnt0 (.clk(clk), .rst_n(rst), .clr(clr), .en(ack0), .cnt(cnt0));
  ack_sat_cnt #(.W(CNT_W)) u_cnt1 (.clk(clk), .rst_n(rst), .clr(clr), .en(ack1), .cnt(cnt1));
  ack_sat_cnt #(.W(CNT_W)) u_cnt2 (.clk(clk), .rst_n(rst), .clr(clr), .en(ack2), .cnt(cnt2));
  ack_sat_cnt #(.W(CNT_W)) u_cnt3 (.clk(clk), .rst_n(rst), .clr(clr), .en(ack3), .cnt(cnt3));

endmodule

// File: tb/tb_ack_or.sv
// Directed self-checking bench for ack_or; a second instance with 2-bit
// counters shares the stimulus to exercise saturation.
module tb_ack_or;
  import ack_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  ack_or_if bus ();

  logic       err_multi, err_multi_s;
  src_mask_t  err_src, err_src_s;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
  logic [1:0] s_cnt0, s_cnt1, s_cnt2, s_cnt3;
  logic       s_ack, s_multi;
  src_idx_t   s_src;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ack_or dut (
    .ack0(bus.ack0), .ack1(bus.ack1), .ack2(bus.ack2), .ack3(bus.ack3),
    .ack(bus.ack), .clk(clk), .rst(rst),
    .ack_src(bus.ack_src), .ack_multi(bus.ack_multi),
    .err_multi(err_multi), .err_src(err_src),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .clr(clr)
  );

  ack_or #(.CNT_W(2)) dut_sat (
    .ack0(bus.ack0), .ack1(bus.ack1), .ack2(bus.ack2), .ack3(bus.ack3),
    .ack(s_ack), .clk(clk), .rst(rst),
    .ack_src(s_src), .ack_multi(s_multi),
    .err_multi(err_multi_s), .err_src(err_src_s),
    .cnt0(s_cnt0), .cnt1(s_cnt1), .cnt2(s_cnt2), .cnt3(s_cnt3), .clr(clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_acks(input logic [3:0] m);
    {bus.ack3, bus.ack2, bus.ack1, bus.ack0} = m;
  endtask

  task automatic check_cnts(input string tag, input int c0, c1, c2, c3);
    check({tag, ".cnt0"}, 32'(cnt0), 32'(c0));
    check({tag, ".cnt1"}, 32'(cnt1), 32'(c1));
    check({tag, ".cnt2"}, 32'(cnt2), 32'(c2));
    check({tag, ".cnt3"}, 32'(cnt3), 32'(c3));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sat[5];
    exp_sat = '{1, 2, 3, 3, 3};

    // Reset phase, 10 ns
    rst = 1'b0; clr = 1'b0; set_acks(4'b0000);
    #1;
    check("rst.ack", 32'(bus.ack), 0);
    check("rst.err_multi", 32'(err_multi), 0);
    check("rst.err_src", 32'(err_src), 0);
    check_cnts("rst", 0, 0, 0, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst.err_src", 32'(err_src), 0);
    check_cnts("post_rst", 0, 0, 0, 0);

    // Walking acknowledge with clean handovers
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_acks(4'b0001 << i);
      #1;
      check($sformatf("walk%0d.ack", i), 32'(bus.ack), 1);
      check($sformatf("walk%0d.src", i), 32'(bus.ack_src), 32'(i));
      check($sformatf("walk%0d.multi", i), 32'(bus.ack_multi), 0);
    end
    @(negedge clk); set_acks(4'b0000);
    #1;
    check("walk_end.ack", 32'(bus.ack), 0);
    check("walk_end.err_multi", 32'(err_multi), 0);
    check_cnts("walk_end", 1, 1, 1, 1);

    // Idle for 50 ns
    repeat (5) @(negedge clk);
    check("idle.ack", 32'(bus.ack), 0);
    check("idle.src", 32'(bus.ack_src), 0);
    check_cnts("idle", 1, 1, 1, 1);

    // Multi-ack on sources 1 and 3
    set_acks(4'b1010);
    #1;
    check("multi.ack", 32'(bus.ack), 1);
    check("multi.src", 32'(bus.ack_src), 1);
    check("multi.ack_multi", 32'(bus.ack_multi), 1);
    check("multi.err_before_edge", 32'(err_multi), 0);
    @(negedge clk); set_acks(4'b0000);
    #1;
    check("multi.err_multi", 32'(err_multi), 1);
    check("multi.err_src", 32'(err_src), 32'h0000000a);
    check("multi.ack_multi_low", 32'(bus.ack_multi), 0);
    @(negedge clk);
    check("sticky.err_multi", 32'(err_multi), 1);
    check("sticky.err_src", 32'(err_src), 32'h0000000a);
    check_cnts("sticky", 1, 2, 1, 2);

    // Synchronous clear
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("clr.err_multi", 32'(err_multi), 0);
    check("clr.err_src", 32'(err_src), 0);
    check_cnts("clr", 0, 0, 0, 0);

    // clr wins over a coincident multi-ack
    clr = 1'b1; set_acks(4'b0011);
    @(posedge clk); #1;
    check("clr_vs_multi.err_multi", 32'(err_multi), 0);
    check("clr_vs_multi.err_src", 32'(err_src), 0);
    check("clr_vs_multi.cnt0", 32'(cnt0), 0);
    @(negedge clk); clr = 1'b0; set_acks(4'b0000);

    // Saturation on the 2-bit instance: hold ack0 for five edges
    @(negedge clk); set_acks(4'b0001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("sat%0d.cnt0", i), 32'(s_cnt0), 32'(exp_sat[i]));
      check($sformatf("sat%0d.wide_cnt0", i), 32'(cnt0), 32'(i + 1));
    end
    @(negedge clk); set_acks(4'b0000);

    // Async reset while ack2 is held
    @(negedge clk); set_acks(4'b0100);
    @(posedge clk); #1;
    check("arst.cnt2_before", 32'(cnt2), 1);
    #2 rst = 1'b0;
    #1;
    check("arst.cnt2_cleared", 32'(cnt2), 0);
    check("arst.cnt0_cleared", 32'(cnt0), 0);
    check("arst.ack", 32'(bus.ack), 1);
    check("arst.src", 32'(bus.ack_src), 2);
    @(posedge clk); #1;
    check("arst.no_count_in_reset", 32'(cnt2), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("arst.resume", 32'(cnt2), 1);
    @(negedge clk); set_acks(4'b0000);
    #1;
    check("final.ack", 32'(bus.ack), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
